// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST initiator: FSM state encoding,
// the Galois polynomial shared by the LFSRs and the MISR, and the MISR start value.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

    function automatic logic [31:0] poly_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and single-step enable;
// load has priority over step.
module lfsr32
    import alu_bist_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] state_d;
    logic [31:0] state_q;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = poly_step(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test initiator: LFSR stimulus, MISR compaction, golden compare.
// Optional `ALU_BIST_ABORT_EN adds an abort input that cancels a run in progress.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ST_IDLE   | waiting for start; ALU inputs hold
// ST_DRIVE  | operands/opcode stable, ALU result settling
// ST_SAMPLE | result compacted into MISR, stimulus steps on exit
// ST_DONE   | one-cycle done pulse; pass registered on exit
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int          WIDTH          = 32,
    parameter int          NUM_VECTORS    = 16,
    parameter int          NUM_OPS        = 16,
    parameter logic [31:0] SEED_A         = 32'h1,
    parameter logic [31:0] SEED_B         = 32'h2,
    parameter logic [31:0] GOLD_SIGNATURE = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ALU_BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      vec_count
);

    localparam logic [31:0] SEED_A_EFF = fix_seed(SEED_A);
    localparam logic [31:0] SEED_B_EFF = fix_seed(SEED_B);
    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [4:0]  LAST_OP    = 5'(NUM_OPS - 1);

    state_t      state_d, state_q;
    logic [4:0]  op_d, op_q;
    logic [31:0] misr_d, misr_q;
    logic [15:0] vcnt_d, vcnt_q;
    logic        busy_d, busy_q;
    logic        done_d, done_q;
    logic        pass_d, pass_q;
    logic        lfsr_load;
    logic        lfsr_step;
    logic        abort_req;

`ifdef ALU_BIST_ABORT_EN
    assign abort_req = abort && ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE));
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        misr_d    = misr_q;
        vcnt_d    = vcnt_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    lfsr_load = 1'b1;
                    op_d      = 5'd0;
                    misr_d    = MISR_INIT;
                    vcnt_d    = 16'd0;
                    pass_d    = 1'b0;
                end
            end
            ST_DRIVE: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                lfsr_step = 1'b1;
                misr_d    = poly_step(misr_q) ^ alu_result;
                op_d      = (op_q == LAST_OP) ? 5'd0 : op_q + 5'd1;
                vcnt_d    = vcnt_q + 16'd1;
                state_d   = (vcnt_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pass_d  = (misr_q == GOLD_SIGNATURE);
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort freezes the partial signature and count where they are.
        if (abort_req) begin
            state_d   = ST_IDLE;
            lfsr_step = 1'b0;
            op_d      = op_q;
            misr_d    = misr_q;
            vcnt_d    = vcnt_q;
        end

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 5'd0;
            misr_q  <= MISR_INIT;
            vcnt_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            misr_q  <= misr_d;
            vcnt_q  <= vcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    lfsr32 #(.RESET_VAL(SEED_A_EFF)) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (SEED_A_EFF),
        .state (alu_a)
    );

    lfsr32 #(.RESET_VAL(SEED_B_EFF)) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (SEED_B_EFF),
        .state (alu_b)
    );

    assign alu_op    = op_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign vec_count = vcnt_q;

endmodule

// File: doc/alu_bist.md
# alu_bist

Synthesizable built-in self-test initiator for the integer ALU. It generates pseudo-random `{a, b, op}` stimulus from two LFSRs, drives it into the ALU's operand/opcode inputs, and compacts each returned result into a MISR signature. On completion it compares the signature against a golden constant and reports pass/fail. It sits beside the ALU in the core and shares its ports through a test-mode mux owned by the integrating level.

## Interface
- `WIDTH`, 32 — operand width; only 32 is supported because the LFSR and MISR taps are fixed.
- `NUM_VECTORS`, 16 — vectors per run; range 1..65535.
- `NUM_OPS`, 16 — opcodes exercised; the op counter cycles 0..NUM_OPS-1; range 1..32.
- `SEED_A`, 32'h1 — initial value of LFSR A; 0 is replaced by 32'h1.
- `SEED_B`, 32'h2 — initial value of LFSR B; 0 is replaced by 32'h1.
- `GOLD_SIGNATURE`, 32'h0 — expected final MISR value.

Ports:
- `clk` in 1 — single clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle request to begin a run; ignored unless the block is IDLE.
- `alu_a` out 32 — operand A, driven from LFSR A.
- `alu_b` out 32 — operand B, driven from LFSR B.
- `alu_op` out 5 — opcode, driven from the op counter.
- `alu_result` in 32 — combinational ALU result.
- `busy` out 1 — high in DRIVE and SAMPLE.
- `done` out 1 — one-cycle pulse in DONE.
- `pass` out 1 — registered `signature == GOLD_SIGNATURE`; held until the next start.
- `signature` out 32 — current MISR value.
- `vec_count` out 16 — number of vectors compacted so far.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE + start → DRIVE. On this edge: LFSRs ← seeds, op counter ← 0, MISR ← 32'hFFFFFFFF, `vec_count` ← 0, `pass` ← 0.
  - DRIVE → SAMPLE unconditionally. ALU inputs settle during this cycle.
  - SAMPLE → DRIVE, or → DONE when `vec_count+1 == NUM_VECTORS`. On this edge:
    - MISR steps with `alu_result`.
    - Both LFSRs step once.
    - Op counter increments and wraps at NUM_OPS.
    - `vec_count` increments.
  - DONE → IDLE. On this edge `pass` is registered.
- LFSR step is Galois, polynomial 32'h80200003: `next = {s[30:0],1'b0} ^ (s[31] ? 32'h80200003 : 0)`.
- MISR step: `sig = {sig[30:0],1'b0} ^ (sig[31] ? 32'h80200003 : 0) ^ alu_result`.
- `alu_a`, `alu_b`, `alu_op` are the state registers themselves, with no combinational path from inputs. They hold their value in IDLE and DONE.
- `start` while busy or in DONE is ignored, with no queuing.

## Timing
- Reset values:
  - `alu_a` = SEED_A, `alu_b` = SEED_B, `alu_op` = 0.
  - `busy` = 0, `done` = 0, `pass` = 0.
  - `signature` = 32'hFFFFFFFF, `vec_count` = 0.
  - State = IDLE.
- Each vector takes 2 cycles. With `start` sampled at edge E, `busy` is high from E through E+2N, and `done` is high for the cycle following edge E+2N.
- `alu_result` is sampled at the SAMPLE→ edge and must be valid one full cycle after the inputs change.
- `rst_n` asserted mid-run aborts the run immediately, and all outputs return to their reset values asynchronously.
- Back-to-back runs: `start` in the cycle after DONE (the block is then IDLE) is accepted.

## Configuration
- `ALU_BIST_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in DRIVE or SAMPLE forces IDLE at the next edge: `busy` falls, `done` is not pulsed, `pass` stays 0, and `signature`/`vec_count` hold their partial values.
  - `abort` in IDLE or DONE is ignored, and `abort` takes priority over `start`.
- Undefined: the port is absent and a run always completes.

## Structure
- Shared package `alu_bist_pkg`: state enum, `LFSR_POLY = 32'h80200003`, `MISR_INIT = 32'hFFFFFFFF`.
- One sub-module, `lfsr32`: load/step enables and a seed input. It is instantiated twice (A, B).
- The MISR is inline; it uses the same polynomial as `lfsr32` plus the XOR-in of `alu_result`.

## Test plan
- Reset check: after reset, `alu_a`=1, `alu_b`=2, `alu_op`=0, `signature`=FFFFFFFF, and `busy`, `done`, `pass` are all 0.
- Single-vector run: NUM_VECTORS=1, NUM_OPS=1, SEED_A=5, SEED_B=3, op 0 = add model.
  - Start → result 8 sampled, `signature`=32'h7FDFFFF5.
  - `done` pulses 2 cycles after the start edge.
  - `pass`=1 when GOLD_SIGNATURE=32'h7FDFFFF5, else 0.
- Default parameters, real ALU model:
  - Vector 1 drives `alu_a`=2, `alu_b`=4, `alu_op`=1.
  - `done` arrives 32 cycles after the start edge.
  - `vec_count`=16 at done.
  - The signature matches a C reference model.
- Op wrap: NUM_OPS=3, NUM_VECTORS=7 → the `alu_op` sequence is 0,1,2,0,1,2,0.
- `start` pulsed during busy and during DONE → ignored. `start` in the cycle after DONE → a second run with a signature identical to the first.
- `rst_n` low at vector 5 → outputs return to reset values the same cycle. With `ALU_BIST_ABORT_EN`, `abort` at vector 5 → IDLE, no `done`, `vec_count`=5.
